chord_song_reader: RTL and testbench

CHORD_SONG_READER -- requirements
Module: chord_song_reader

---
 rtl/chord_song_reader.sv | 135 +++++++++++++
 tb/tb_chord_song_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chord_song_reader.sv
// chord_song_reader: walks one song of a chord ROM and emits note load pulses.
// Each ROM entry is either a note (loaded downstream) or an advance (wait for beats).
// A note entry with zero duration terminates the song; running off the last index
// also ends the song, so the index never silently wraps back to 0.
module chord_song_reader #(
   parameter int unsigned INDEX_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   play,
   input  logic                   beat,
   input  logic [1:0]             song,
   output logic [INDEX_WIDTH+1:0] rom_addr,
   input  logic [15:0]            rom_data,
   output logic                   load_new_note,
   output logic [5:0]             note_to_load,
   output logic [5:0]             duration_to_load,
   output logic                   song_done
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StAdvance,
      StDone
   } state_e;

   localparam logic [INDEX_WIDTH-1:0] LastIndex = '1;

   state_e                 state;
   logic [INDEX_WIDTH-1:0] index;
   logic [5:0]             counter;
   logic [1:0]             song_latched;

   logic       entry_is_advance;
   logic [5:0] entry_note;
   logic [5:0] entry_field;
   logic       song_changed;
   logic       at_last;
   logic       step_now;
   logic       unused_rom_bits;

   assign entry_is_advance = rom_data[15];
   assign entry_note       = rom_data[14:9];
   assign entry_field      = rom_data[8:3];
   assign unused_rom_bits  = ^rom_data[2:0];
   assign song_changed     = (song != song_latched);
   assign at_last          = (index == LastIndex);

   // ROM address is the latched song plus the current entry; stable through FETCH/DECODE.
   assign rom_addr = {song_latched, index};

   // Finished with the current entry this cycle: move to the next one (or end of song).
   always_comb begin
      step_now = 1'b0;
      if (play && !song_changed) begin
         if (state == StDecode) begin
            step_now = entry_is_advance ? (entry_field == 6'd0) : (entry_field != 6'd0);
         end else if (state == StAdvance) begin
            step_now = beat && (counter == 6'd1);
         end
      end
   end

   // Sequencer state, index/counter bookkeeping and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= StIdle;
         index            <= '0;
         counter          <= 6'd0;
         song_latched     <= 2'd0;
         load_new_note    <= 1'b0;
         song_done        <= 1'b0;
         note_to_load     <= 6'd0;
         duration_to_load <= 6'd0;
      end else begin
         load_new_note <= 1'b0;
         song_done     <= 1'b0;
         if (state != StIdle && song_changed) begin
            // A new song request abandons the current one before anything is emitted.
            state   <= StIdle;
            index   <= '0;
            counter <= 6'd0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (play) begin
                     song_latched <= song;
                     state        <= StFetch;
                  end
               end
               StFetch: begin
                  if (play) state <= StDecode;
               end
               StDecode: begin
                  if (play) begin
                     if (!entry_is_advance) begin
                        if (entry_field == 6'd0) begin
                           song_done <= 1'b1;
                           state     <= StDone;
                        end else begin
                           note_to_load     <= entry_note;
                           duration_to_load <= entry_field;
                           load_new_note    <= 1'b1;
                        end
                     end else begin
                        counter <= entry_field;
                        if (entry_field != 6'd0) state <= StAdvance;
                     end
                  end
               end
               StAdvance: begin
                  if (play && beat && counter != 6'd0) counter <= counter - 6'd1;
               end
               StDone: begin
                  state <= StDone;
               end
               default: state <= StIdle;
            endcase
            // Overrides the case's next state when the entry is complete.
            if (step_now) begin
               if (at_last) begin
                  song_done <= 1'b1;
                  state     <= StDone;
               end else begin
                  index <= index + 1'b1;
                  state <= StFetch;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_chord_song_reader.sv
// Bench for chord_song_reader: timeline reference model over scripted and random
// play/beat patterns, plus directed song-change, reset-on-load and wrap scenarios.
module tb_chord_song_reader;

   localparam int MAXC = 300;

   logic        clk = 1'b0;
   logic        reset, play, beat;
   logic [1:0]  song;
   logic [6:0]  rom_addr;
   logic [15:0] rom_data;
   logic        load_new_note, song_done;
   logic [5:0]  note_to_load, duration_to_load;

   logic [3:0]  rom_addr_w;
   logic [15:0] rom_data_w;
   logic        load_w, done_w;
   logic [5:0]  note_w, dur_w;

   logic [15:0] rom0 [128];
   logic [15:0] rom_w [16];

   int checks = 0;
   int errors = 0;

   bit play_v [MAXC];
   bit beat_v [MAXC];
   bit exp_load [MAXC+2];
   bit exp_done [MAXC+2];
   bit exp_av [MAXC+2];
   int exp_note [MAXC+2];
   int exp_dur [MAXC+2];
   int exp_addr [MAXC+2];
   int held_note, held_dur;

   always #5 clk = ~clk;

   chord_song_reader #(.INDEX_WIDTH(5)) dut (
      .clk(clk), .reset(reset), .play(play), .beat(beat), .song(song),
      .rom_addr(rom_addr), .rom_data(rom_data), .load_new_note(load_new_note),
      .note_to_load(note_to_load), .duration_to_load(duration_to_load), .song_done(song_done)
   );

   chord_song_reader #(.INDEX_WIDTH(2)) dut_w (
      .clk(clk), .reset(reset), .play(play), .beat(beat), .song(song),
      .rom_addr(rom_addr_w), .rom_data(rom_data_w), .load_new_note(load_w),
      .note_to_load(note_w), .duration_to_load(dur_w), .song_done(done_w)
   );

   // Synchronous ROMs: data for an address appears one cycle later.
   always @(posedge clk) begin
      rom_data   <= rom0[rom_addr];
      rom_data_w <= rom_w[rom_addr_w];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ent_note(input int n, input int d);
      return {1'b0, 6'(n), 6'(d), 3'b000};
   endfunction

   function automatic logic [15:0] ent_adv(input int k);
      return {1'b1, 6'd0, 6'(k), 3'b000};
   endfunction

   function automatic logic [15:0] ent_term();
      return {1'b0, 6'd5, 6'd0, 3'b101};
   endfunction

   task automatic clear_rom();
      for (int a = 0; a < 128; a++) rom0[a] = ent_term();
   endtask

   task automatic do_reset(input int s);
      reset = 1'b1;
      play  = 1'b0;
      beat  = 1'b0;
      song  = 2'(s);
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b0;
      held_note = 0;
      held_dur  = 0;
   endtask

   function automatic int next_active(input int from, input int ncyc);
      for (int n = from; n < ncyc; n++) if (play_v[n]) return n;
      return ncyc;
   endfunction

   // Walks the song over the play/beat timeline: every state step costs one cycle
   // with play=1, advances wait for k beats seen while play=1, pulses appear one cycle later.
   task automatic build_expect(input int ncyc, input int s);
      int i, st, f, d, e, k, seen;
      logic [15:0] w;
      for (int n = 0; n < MAXC + 2; n++) begin
         exp_load[n] = 0; exp_done[n] = 0; exp_av[n] = 0;
         exp_note[n] = 0; exp_dur[n] = 0; exp_addr[n] = 0;
      end
      i  = 0;
      st = next_active(0, ncyc) + 1;
      while (st < ncyc) begin
         f = next_active(st, ncyc);
         d = (f >= ncyc) ? ncyc : next_active(f + 1, ncyc);
         for (int n = st; n <= d && n < ncyc; n++) begin
            exp_av[n]   = 1;
            exp_addr[n] = s * 32 + i;
         end
         if (d >= ncyc) break;
         w = rom0[s * 32 + i];
         e = d;
         if (!w[15]) begin
            if (w[8:3] == 6'd0) begin
               exp_done[d+1] = 1;
               break;
            end
            exp_load[d+1] = 1;
            exp_note[d+1] = int'(w[14:9]);
            exp_dur[d+1]  = int'(w[8:3]);
         end else begin
            k = int'(w[8:3]);
            if (k != 0) begin
               seen = 0;
               e    = -1;
               for (int n = d + 1; n < ncyc; n++) begin
                  if (play_v[n] && beat_v[n]) begin
                     seen++;
                     if (seen == k) begin
                        e = n;
                        break;
                     end
                  end
               end
               if (e < 0) break;
            end
         end
         if (i == 31) begin
            exp_done[e+1] = 1;
            break;
         end
         i++;
         st = e + 1;
      end
   endtask

   task automatic check_cycle(input int c);
      if (exp_load[c]) begin
         held_note = exp_note[c];
         held_dur  = exp_dur[c];
      end
      chk("load", 32'(load_new_note), 32'(exp_load[c]));
      chk("done", 32'(song_done), 32'(exp_done[c]));
      chk("note", 32'(note_to_load), 32'(held_note));
      chk("dur", 32'(duration_to_load), 32'(held_dur));
      if (exp_av[c]) chk("addr", 32'(rom_addr), 32'(exp_addr[c]));
   endtask

   task automatic play_run(input int ncyc, input int s);
      build_expect(ncyc, s);
      do_reset(s);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      check_cycle(0);
      for (int n = 0; n < ncyc; n++) begin
         play = play_v[n];
         beat = beat_v[n];
         @(posedge clk);
         #1;
         check_cycle(n + 1);
      end
   endtask

   initial begin
      int s, len, ld_cnt, dn_cnt, dn_cyc, last_note, ld_idx;
      reset = 1'b1; play = 1'b0; beat = 1'b0; song = 2'd0;
      for (int a = 0; a < 16; a++) rom_w[a] = ent_term();
      rom_w[0] = ent_note(1, 1);
      rom_w[1] = ent_note(2, 2);
      rom_w[2] = ent_note(3, 3);
      rom_w[3] = ent_note(4, 4);

      // Two notes then terminator.
      clear_rom();
      rom0[0] = ent_note(6'h20, 8);
      rom0[1] = ent_note(6'h22, 4);
      for (int n = 0; n < MAXC; n++) begin play_v[n] = 1; beat_v[n] = 0; end
      play_run(20, 0);

      // Chord then advance 3, beat every 4th cycle.
      clear_rom();
      rom0[0] = ent_note(10, 16);
      rom0[1] = ent_note(14, 16);
      rom0[2] = ent_adv(3);
      rom0[3] = ent_note(17, 8);
      for (int n = 0; n < MAXC; n++) begin play_v[n] = 1; beat_v[n] = (n % 4 == 3); end
      play_run(60, 0);

      // Pause with 2 beats outstanding, 5 beats while paused.
      clear_rom();
      rom0[0] = ent_adv(4);
      rom0[1] = ent_note(17, 8);
      for (int n = 0; n < MAXC; n++) begin
         play_v[n] = !(n >= 10 && n < 26);
         beat_v[n] = (n == 6) || (n == 8) || (n >= 12 && n <= 20 && n % 2 == 0) ||
                     (n == 30) || (n == 34);
      end
      play_run(50, 0);

      // Random songs, random play/beat.
      for (int r = 0; r < 6; r++) begin
         clear_rom();
         s   = int'($urandom_range(0, 3));
         len = int'($urandom_range(3, 10));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) < 7)
               rom0[s*32+i] = ent_note(int'($urandom_range(0, 63)), int'($urandom_range(1, 20)));
            else
               rom0[s*32+i] = ent_adv(int'($urandom_range(0, 3)));
            rom0[s*32+i][2:0] = 3'($urandom_range(0, 7));
         end
         for (int n = 0; n < MAXC; n++) begin
            play_v[n] = ($urandom_range(0, 9) < 8);
            beat_v[n] = ($urandom_range(0, 3) == 0);
         end
         play_run(MAXC, s);
      end

      // Song change 0->2 on the final beat of an advance.
      clear_rom();
      rom0[0]  = ent_note(1, 1);
      rom0[1]  = ent_adv(2);
      rom0[2]  = ent_note(9, 9);
      rom0[64] = ent_note(5, 3);
      do_reset(0);
      for (int n = 0; n < 14; n++) begin
         play = 1'b1;
         beat = (n == 6) || (n == 8);
         song = (n >= 8) ? 2'd2 : 2'd0;
         @(posedge clk);
         #1;
         if (n + 1 == 9) begin
            chk("sc_load", 32'(load_new_note), 32'd0);
            chk("sc_done", 32'(song_done), 32'd0);
            chk("sc_idle_addr", 32'(rom_addr), 32'd0);
         end
         if (n + 1 == 10) chk("sc_fetch_addr", 32'(rom_addr), 32'd64);
         if (n + 1 == 12) begin
            chk("sc_load2", 32'(load_new_note), 32'd1);
            chk("sc_note2", 32'(note_to_load), 32'd5);
            chk("sc_dur2", 32'(duration_to_load), 32'd3);
         end
      end

      // Reset arriving in the cycle a load pulse is due.
      clear_rom();
      rom0[0] = ent_note(6'h11, 7);
      rom0[1] = ent_note(6'h2a, 9);
      do_reset(0);
      for (int n = 0; n < 5; n++) begin
         play  = 1'b1;
         reset = (n == 4);
         @(posedge clk);
         #1;
         if (n + 1 == 3) chk("rl_first_note", 32'(note_to_load), 32'h11);
         if (n + 1 == 5) begin
            chk("rl_load", 32'(load_new_note), 32'd0);
            chk("rl_note", 32'(note_to_load), 32'd0);
            chk("rl_dur", 32'(duration_to_load), 32'd0);
            chk("rl_done", 32'(song_done), 32'd0);
            chk("rl_addr", 32'(rom_addr), 32'd0);
         end
      end
      reset = 1'b0;

      // Wrap with a 4-entry song and no terminator.
      do_reset(0);
      ld_cnt = 0; dn_cnt = 0; dn_cyc = -1; last_note = -1;
      for (int n = 0; n < 30; n++) begin
         play = 1'b1;
         @(posedge clk);
         #1;
         if (load_w) begin
            ld_idx = ld_cnt;
            chk("wrap_load_cycle", 32'(n + 1), 32'(3 + 2 * ld_idx));
            ld_cnt++;
            last_note = int'(note_w);
         end
         if (done_w) begin
            dn_cnt++;
            dn_cyc = n + 1;
         end
      end
      chk("wrap_loads", 32'(ld_cnt), 32'd4);
      chk("wrap_dones", 32'(dn_cnt), 32'd1);
      chk("wrap_done_cycle", 32'(dn_cyc), 32'd9);
      chk("wrap_last_note", 32'(last_note), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
